// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Holds the default widths, the queued-entry layout and the youngest-match search.
package wb_pkg;

  localparam int REG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_CAND   = 64;

  typedef struct packed {
    logic [REG_W_DEF-1:0]  wn;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // Candidates are ordered oldest at bit 0 to youngest at the top bit.
  // The result is the index of the youngest set bit.
  function automatic logic [5:0] youngest_match(input logic [MAX_CAND-1:0] m);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (m[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Circular buffer accepting up to two pushes and one pop per cycle.
// Entries are exposed in age order (index 0 = head) for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [1:0]                 push_cnt_i,
  input  entry_t                     din0_i,
  input  entry_t                     din1_i,
  input  logic                       pop_i,
  output entry_t                     entries_o [DEPTH],
  output logic [DEPTH-1:0]           valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_cnt_i != 2'd0) mem_q[wr_ptr_q] <= din0_i;
      if (push_cnt_i == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= din1_i;
      wr_ptr_q <= wr_ptr_q + PW'(push_cnt_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_i);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries_o[k] = mem_q[rd_ptr_q + PW'(k)];
      valid_o[k]   = (CW'(k) < count_q);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Write-side front end of the register file: merges load and ALU writes in order,
// drains one per cycle into the write port and offers forwarding of pending values.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   ld_we,
  input  logic [REG_W-1:0]       ld_wn,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   alu_we,
  input  logic [REG_W-1:0]       alu_wn,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   in_ready,
  output logic                   we,
  output logic [REG_W-1:0]       wn,
  output logic [DATA_W-1:0]      data,
  input  logic [REG_W-1:0]       rna,
  input  logic [REG_W-1:0]       rnb,
  output logic                   fwd_a_hit,
  output logic                   fwd_b_hit,
  output logic [DATA_W-1:0]      fwd_a,
  output logic [DATA_W-1:0]      fwd_b,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NCAND = DEPTH + 1;

  typedef struct packed {
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              ld_v, alu_v, pop, drop;
  logic [1:0]        n_req, push_cnt;
  logic [CW:0]       free;
  entry_t            din0, din1;
  entry_t            fifo_entries [DEPTH];
  logic [DEPTH-1:0]  fifo_valid;
  logic [CW-1:0]     fifo_count;

  logic              we_q, we_d, overflow_q, overflow_d;
  logic [REG_W-1:0]  wn_q, wn_d;
  logic [DATA_W-1:0] data_q, data_d;

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk        (clk),
    .clr        (clr),
    .push_cnt_i (push_cnt),
    .din0_i     (din0),
    .din1_i     (din1),
    .pop_i      (pop),
    .entries_o  (fifo_entries),
    .valid_o    (fifo_valid),
    .count_o    (fifo_count)
  );

  // Free space is judged after this cycle's pop; a single free slot goes to the load.
  always_comb begin
    ld_v     = ld_we  && (ld_wn  != '0);
    alu_v    = alu_we && (alu_wn != '0);
    pop      = (fifo_count != '0);
    free     = (CW+1)'(DEPTH) - {1'b0, fifo_count} + {{CW{1'b0}}, pop};
    n_req    = {1'b0, ld_v} + {1'b0, alu_v};
    push_cnt = n_req;
    drop     = 1'b0;
    if (free < {{(CW-1){1'b0}}, n_req}) begin
      push_cnt = free[1:0];
      drop     = 1'b1;
    end
    din0.wn   = ld_v ? ld_wn   : alu_wn;
    din0.data = ld_v ? ld_data : alu_data;
    din1.wn   = alu_wn;
    din1.data = alu_data;
  end

  always_comb begin
    we_d       = pop;
    wn_d       = pop ? fifo_entries[0].wn   : wn_q;
    data_d     = pop ? fifo_entries[0].data : data_q;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      we_q       <= 1'b0;
      wn_q       <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      we_q       <= we_d;
      wn_q       <= wn_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  logic [REG_W-1:0]  rn  [2];
  logic              hit [2];
  logic [DATA_W-1:0] val [2];

  assign rn[0] = rna;
  assign rn[1] = rnb;

  // Candidate bit 0 is the output register (oldest), bits 1..DEPTH the queue by age.
  always_comb begin
    logic [NCAND-1:0] cand;
    logic [5:0]       idx;
    for (int p = 0; p < 2; p++) begin
      cand    = '0;
      cand[0] = we_q && (wn_q == rn[p]);
      for (int k = 0; k < DEPTH; k++) begin
        cand[k+1] = fifo_valid[k] && (fifo_entries[k].wn == rn[p]);
      end
      if (rn[p] == '0) cand = '0;
      idx    = youngest_match(MAX_CAND'(cand));
      hit[p] = |cand;
      val[p] = '0;
      if (hit[p]) begin
        val[p] = data_q;
        for (int k = 0; k < DEPTH; k++) begin
          if (idx == 6'(k + 1)) val[p] = fifo_entries[k].data;
        end
      end
    end
  end

  assign in_ready  = ((CW+1)'(DEPTH) - {1'b0, fifo_count}) >= (CW+1)'(2);
  assign we        = we_q;
  assign wn        = wn_q;
  assign data      = data_q;
  assign overflow  = overflow_q;
  assign count     = fifo_count;
  assign fwd_a_hit = hit[0];
  assign fwd_b_hit = hit[1];
  assign fwd_a     = val[0];
  assign fwd_b     = val[1];

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a queue-level model predicts writes,
// occupancy, overflow and forwarding; a negedge monitor compares against the DUT.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        ld_we, alu_we;
  logic [4:0]  ld_wn, alu_wn, rna, rnb, wn;
  logic [31:0] ld_data, alu_data, data, fwd_a, fwd_b;
  logic        in_ready, we, fwd_a_hit, fwd_b_hit, overflow;
  logic [2:0]  count;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .ld_we(ld_we), .ld_wn(ld_wn), .ld_data(ld_data),
    .alu_we(alu_we), .alu_wn(alu_wn), .alu_data(alu_data),
    .in_ready(in_ready), .we(we), .wn(wn), .data(data),
    .rna(rna), .rnb(rnb),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .count(count), .overflow(overflow)
  );

  typedef struct {
    logic [4:0]  wn;
    logic [31:0] data;
  } wr_t;

  wr_t         m_q[$];    // pending writes, oldest first
  wr_t         exp_q[$];  // writes the DUT still owes us
  logic        m_we = 1'b0, m_ovf = 1'b0;
  logic [4:0]  m_wn = '0;
  logic [31:0] m_data = '0;
  int          tests = 0, fails = 0;
  bit          mon_en = 1'b0, rn_rand = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic take(input logic [4:0] w, input logic [31:0] d, inout int free);
    wr_t e;
    e.wn = w; e.data = d;
    if (free > 0) begin
      m_q.push_back(e);
      exp_q.push_back(e);
      free--;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_edge();
    int  free;
    wr_t h;
    if (clr) begin
      m_q.delete(); exp_q.delete();
      m_we = 1'b0; m_wn = '0; m_data = '0; m_ovf = 1'b0;
    end else begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_we = 1'b1; m_wn = h.wn; m_data = h.data;
      end else begin
        m_we = 1'b0;
      end
      free = DEPTH - m_q.size();
      if (ld_we  && ld_wn  != 0) take(ld_wn,  ld_data,  free);
      if (alu_we && alu_wn != 0) take(alu_wn, alu_data, free);
    end
  endtask

  function automatic void mfwd(input logic [4:0] rn, output logic hit, output logic [31:0] v);
    hit = 1'b0; v = '0;
    if (rn != 0) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (m_q[i].wn == rn) begin hit = 1'b1; v = m_q[i].data; break; end
      end
      if (!hit && m_we && m_wn == rn) begin hit = 1'b1; v = m_data; end
    end
  endfunction

  task automatic cyc(input bit c, input bit lw, input logic [4:0] lwn, input logic [31:0] ld,
                     input bit aw, input logic [4:0] awn, input logic [31:0] ad);
    clr = c; ld_we = lw; ld_wn = lwn; ld_data = ld; alu_we = aw; alu_wn = awn; alu_data = ad;
    if (rn_rand) begin
      rna = 5'($urandom_range(0, 7));
      rnb = 5'($urandom_range(0, 7));
    end
    @(posedge clk);
    model_edge();
    #1;
    clr = 1'b0; ld_we = 1'b0; alu_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    wr_t         e;
    logic        h;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("we", 32'(we), 32'(m_we));
        if (we === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got wn=%0d data=%h expected no write", wn, data);
          end else begin
            e = exp_q.pop_front();
            chk("wn", 32'(wn), 32'(e.wn));
            chk("data", data, e.data);
          end
        end
        chk("count", 32'(count), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("in_ready", 32'(in_ready), 32'(DEPTH - m_q.size() >= 2));
        mfwd(rna, h, v);
        chk("fwd_a_hit", 32'(fwd_a_hit), 32'(h));
        chk("fwd_a", fwd_a, v);
        mfwd(rnb, h, v);
        chk("fwd_b_hit", 32'(fwd_b_hit), 32'(h));
        chk("fwd_b", fwd_b, v);
      end
    end
  end

  initial begin
    bit lw, aw;
    clr = 1'b1; ld_we = 0; alu_we = 0; ld_wn = 0; alu_wn = 0; ld_data = 0; alu_data = 0;
    rna = 0; rnb = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // single write
    cyc(0, 0, 0, 0, 1, 5'd3, 32'h2000_0022);
    idle(3);

    // dual request, same destination, watched on port a
    rn_rand = 1'b0; rna = 5'd5; rnb = 5'd0;
    cyc(0, 1, 5'd5, 32'h4000_0044, 1, 5'd5, 32'h0000_0001);
    @(negedge clk);
    chk("dual_fwd_a", fwd_a, 32'h0000_0001);
    idle(3);

    // r0 filter
    rna = 5'd0;
    cyc(0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_hit", 32'(fwd_a_hit), 32'd0);
    idle(2);
    rn_rand = 1'b1;

    // backpressure, forced drop, drain across the wrap
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 5'(2 * i + 1), $urandom, 1, 5'(2 * i + 2), $urandom);
    cyc(0, 1, 5'd7, 32'h7777_0007, 1, 5'd6, 32'h6666_0006);
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 0, 1, 5'($urandom_range(1, 7)), $urandom);
    idle(6);

    // reset in the middle of a drain
    cyc(0, 1, 5'd1, $urandom, 1, 5'd2, $urandom);
    cyc(0, 1, 5'd3, $urandom, 1, 5'd4, $urandom);
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_we", 32'(we), 32'd0);
    idle(3);

    // randomized traffic, mostly respecting in_ready
    for (int i = 0; i < 500; i++) begin
      lw = ($urandom_range(0, 2) == 0);
      aw = ($urandom_range(0, 1) == 0);
      if ((DEPTH - m_q.size() < 2) && ($urandom_range(0, 9) != 0)) begin lw = 0; aw = 0; end
      cyc(($urandom_range(0, 60) == 0),
          lw, 5'($urandom_range(0, 7)), $urandom,
          aw, 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side front end for the 32x32 register file. It takes register-write requests from two pipeline producers: the MEM/load path and the EX/ALU path. It buffers them in order in a small FIFO and drives the register file's single write port (wn/data/we), one write per cycle. It also gives decode a forwarding lookup for values that are queued or in flight but not yet written into the register file.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- REG_W, 5: register-number width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset, synchronous, active-high.
- ld_we  in  1  load-result write request.
- ld_wn  in  REG_W  load destination register.
- ld_data  in  DATA_W  load result.
- alu_we  in  1  ALU-result write request.
- alu_wn  in  REG_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- in_ready  out  1  high when free slots >= 2; producers may only assert *_we while it is high.
- we  out  1  register-file write enable (registered).
- wn  out  REG_W  register-file write number (registered).
- data  out  DATA_W  register-file write data (registered).
- rna, rnb  in  REG_W  decode read-port numbers.
- fwd_a_hit, fwd_b_hit  out  1  a pending write matches rna / rnb.
- fwd_a, fwd_b  out  DATA_W  forwarded value; 0 when the corresponding hit is low.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky error flag; cleared only by clr.

## Operation
- **Filtering.** A request with wn==0 is discarded: it is not enqueued and does not count toward occupancy.
- **Enqueue order.** When both requests are valid in the same cycle, the load is enqueued first (older instruction), then the ALU result.
- **Dequeue.** Each cycle:
  - If the FIFO is non-empty at the edge, the head is popped into the output register and we=1.
  - Otherwise we=0, while wn and data hold their last values.
- **Occupancy.** count_next = count + n_enq - n_deq. Simultaneous enqueue and dequeue are legal at any occupancy, including full.
- **in_ready.** Combinational from registered count: (DEPTH - count) >= 2.
- **Overflow.** Requests that do not fit are dropped:
  - Free slots are computed after the same-cycle pop.
  - If only one slot is free, the load is kept and the ALU request is dropped.
  - Any dropped request sets overflow=1.
- **Pointers.** Read and write pointers wrap modulo DEPTH.
- **Forwarding, per port.**
  - Candidates are every valid FIFO entry plus the output register when we=1.
  - The youngest match wins: the tail-most FIFO entry first, then the output register.
  - rn==0 never hits.
  - Requests arriving in the current cycle are not candidates; the EX bypass covers them.
- **Reset.** clr has priority over all other activity, including mid-drain. On the clr edge:
  - Pointers, count, we, wn, data and overflow all go to 0.
  - Queued entries are discarded.
  - fwd_*_hit evaluates to 0 from the empty state.

## Timing
- Latency: a request at edge N, into an empty FIFO, gives we=1 with its wn/data during cycle N+1. The register file captures it at the end of N+1, so its read ports return the value from N+2.
- Forwarding covers cycles N+1 through N+1+queue wait. There is no gap between forwarding and register-file visibility.
- Throughput is one write per cycle. Two requests per cycle sustained fill the FIFO by one entry per cycle.
- fwd_* and in_ready are combinational from registered state only. There is no path from *_we to any output within the same cycle.

## Structure
- Package wb_pkg holds:
  - REG_W and DATA_W defaults.
  - Typedef wb_entry_t {wn, data}.
  - A function for the youngest-match search.
- One sub-module, wb_fifo: DEPTH-entry circular buffer with up to two pushes and one pop per cycle. It exposes its entries plus valid bits for the forwarding search.
- The top level holds the output register, the drop and overflow logic, and the forwarding muxes.

## Test plan
- **Single write.** Stimulus: clr for 2 cycles, then alu_we=1, alu_wn=3, alu_data=32'h20000022 for one cycle. Expect we=1, wn=3, data=32'h20000022 on the next cycle, and we=0 after that.
- **Dual request and ordering.** Stimulus: ld (wn=5, 32'h40000044) and alu (wn=5, 32'h1) in the same cycle. Expect:
  - Writes of 32'h40000044 and then 32'h1 on consecutive cycles.
  - With rna=5: fwd_a=32'h1 on both cycles, then hit=0.
- **r0 filter.** Stimulus: alu_wn=0 with data 32'hFFFFFFFF. Expect count to stay 0, we to stay 0, and rna=0 to give fwd_a_hit=0.
- **Backpressure and wrap.** Stimulus: dual requests for 3 cycles with DEPTH=4. Expect:
  - in_ready falls when count reaches 3.
  - Forcing one more dual request drops the ALU entry and sets overflow=1.
  - 10 further single writes drain in order across the pointer wrap.
- **Reset mid-drain.** Stimulus: clr while count=3 and we=1. Expect the next cycle to show we=0, count=0, overflow=0 and fwd hits 0, with no further writes.
